seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a shared 7-segment encoder driving NUM_DIGITS
//  common-anode digits. Holds a display word and steps through digits, presenting one
//  nibble at a time to the hex encoder and enabling that digit. Inserts blank guard time
//  between digits to suppress ghosting. Writes are double-buffered and applied only at
//  frame boundaries (no tearing).
// PARAMETERS
//  NUM_DIGITS    4      digits scanned; display word = 4*NUM_DIGITS bits, digit 0 = LS nibble
//  DWELL_CYCLES  50000  clocks each digit is lit (>=1)
//  GUARD_CYCLES  16     clocks all digits are off before each digit (>=1)
// PORTS
//  i_clk         in   1             system clock; all logic on rising edge
//  i_rstH        in   1             synchronous, active-high reset
//  i_enable      in   1             1 = scan; 0 = display dark, scan parked
//  i_wrEn        in   1             1-cycle strobe: capture i_wrData into shadow
//  i_wrData      in   4*NUM_DIGITS  new display word
//  o_segNibble   out  4             nibble to hex segment encoder
//  o_segBlank    out  1             1 = force encoder segment outputs off
//  o_digitEnN    out  NUM_DIGITS    active-low digit enables, at most one low
//  o_frameDone   out  1             1-cycle pulse at end of each full frame
//  o_pending     out  1             1 = shadow word awaiting frame-boundary transfer
// BEHAVIOUR
//  - Clock: one clock, i_clk. Reset: i_rstH, synchronous, active-high.
//  - Reset (i_rstH sampled high): state GUARD, idx 0, cnt 0, display=0, shadow=0.
//    Outputs after that edge: o_digitEnN all 1, o_segBlank=1, o_segNibble=0,
//    o_frameDone=0, o_pending=0. Reset mid-scan aborts at once.
//  - All outputs are flops updated with the state; no combinational input-to-output paths.
//  - FSM, states GUARD and SHOW; cnt width = $clog2(max(DWELL,GUARD)+1):
//    GUARD: o_digitEnN all 1, o_segBlank=1; lasts exactly GUARD_CYCLES cycles, then SHOW.
//    SHOW:  o_digitEnN[idx]=0, o_segNibble=display[4*idx+:4], o_segBlank=0;
//           lasts exactly DWELL_CYCLES cycles, then GUARD with idx=(idx+1) mod NUM_DIGITS.
//    Leaving SHOW with idx=NUM_DIGITS-1: o_frameDone=1 for the first GUARD cycle only.
//  - Frame period = NUM_DIGITS*(GUARD_CYCLES+DWELL_CYCLES) cycles.
//  - Writes:
//    i_wrEn=1 loads shadow and sets o_pending=1. The write is accepted in any state.
//    Last write before transfer wins.
//  - Frame boundary is the SHOW(NUM_DIGITS-1)->GUARD transition.
//    If pending, display<=shadow and o_pending clears.
//    i_wrEn in that same cycle: the old shadow transfers; the new data lands in shadow
//    and o_pending stays 1.
//  - i_enable=0: next edge forces GUARD, idx=0, cnt=0, dark outputs, o_frameDone=0.
//    Pending shadow transfers on every disabled cycle.
//  - Re-enable runs a full GUARD and then digit 0.
//  - o_segBlank is asserted whenever all digits are off. The encoder output is gated by it.
// CONFIGURATION
//  SEG_SCAN_LZ_BLANK_EN defined: leading-zero blanking. In SHOW for digit k>0, o_segBlank=1
//   if nibbles k..NUM_DIGITS-1 of display are all zero; o_digitEnN timing is unchanged.
//   Digit 0 is never blanked.
//  SEG_SCAN_LZ_BLANK_EN undefined: every digit shows its nibble, including leading zeros.
// TESTING (NUM_DIGITS=4, DWELL_CYCLES=4, GUARD_CYCLES=2)
//  1. i_rstH=1 for 3 cycles -> o_digitEnN=4'hF, o_segBlank=1, o_frameDone=0, o_pending=0.
//  2. Disabled write 16'h1A2F, then enable -> o_segNibble F,2,A,1 with o_digitEnN
//     E,D,B,7, 4 cycles each; 2 dark cycles between digits; o_frameDone every 24 cycles.
//  3. Write 16'h0003 during SHOW digit 1 -> frame finishes as 1A2F with o_pending=1;
//     o_pending clears at boundary; next frame shows 3,0,0,0.
//  4. Write at boundary cycle -> old shadow is shown next frame and o_pending stays 1;
//     the following frame shows the new word.
//  5. i_enable=0 during SHOW digit 2 -> next cycle o_digitEnN=F, o_segBlank=1.
//     Re-enable -> 2 GUARD cycles, then digit 0 lit.
//  6. SEG_SCAN_LZ_BLANK_EN on, word 16'h0030 -> blank during digits 3,2; show 3 and 0.
//     Word 16'h0000 -> only digit 0 shows 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with guard blanking and frame-synchronous double-buffered writes.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int GUARD_CYCLES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rstH,
   input  logic                    i_enable,
   input  logic                    i_wrEn,
   input  logic [4*NUM_DIGITS-1:0] i_wrData,
   output logic [3:0]              o_segNibble,
   output logic                    o_segBlank,
   output logic [NUM_DIGITS-1:0]   o_digitEnN,
   output logic                    o_frameDone,
   output logic                    o_pending,
   output logic                    o_dbgState
);

   localparam int MAX_CYC = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int WW      = 4 * NUM_DIGITS;

   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic {
      GUARD = 1'b0,
      SHOW  = 1'b1
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic [WW-1:0]   display;
   logic [WW-1:0]   shadow;

   logic [3:0]            curNibble;
   logic [NUM_DIGITS-1:0] curOneHot;
   logic                  lzBlank;
   logic                  boundary;
   logic                  xfer;

   assign o_dbgState = (state == SHOW);

   always_comb begin
      curNibble = 4'h0;
      curOneHot = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            curNibble    = display[4*i +: 4];
            curOneHot[i] = 1'b1;
         end
      end
   end

`ifdef SEG_SCAN_LZ_BLANK_EN
   // Walk from the MS nibble down; a digit is blank when it and everything above it is zero.
   always_comb begin
      logic zeroAbove;
      zeroAbove = 1'b1;
      lzBlank   = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zeroAbove = zeroAbove & (display[4*i +: 4] == 4'h0);
         if ((idx == IW'(i)) && (i != 0))
            lzBlank = zeroAbove;
      end
   end
`else
   assign lzBlank = 1'b0;
`endif

   // Write interface: i_wrEn is a ready-less strobe; every cycle it is high is accepted into shadow.
   assign boundary = i_enable && (state == SHOW) && (cnt == DWELL_LAST) && (idx == IDX_LAST);
   assign xfer     = o_pending && (boundary || !i_enable);

   always_ff @(posedge i_clk) begin
      if (i_rstH) begin
         state       <= GUARD;
         idx         <= '0;
         cnt         <= '0;
         display     <= '0;
         shadow      <= '0;
         o_pending   <= 1'b0;
         o_digitEnN  <= '1;
         o_segBlank  <= 1'b1;
         o_segNibble <= 4'h0;
         o_frameDone <= 1'b0;
      end else begin
         if (i_wrEn)
            shadow <= i_wrData;
         if (xfer)
            display <= shadow;
         o_pending <= i_wrEn || (o_pending && !xfer);

         if (!i_enable) begin
            state       <= GUARD;
            idx         <= '0;
            cnt         <= '0;
            o_digitEnN  <= '1;
            o_segBlank  <= 1'b1;
            o_segNibble <= 4'h0;
            o_frameDone <= 1'b0;
         end else begin
            case (state)
               GUARD: begin
                  o_frameDone <= 1'b0;
                  if (cnt == GUARD_LAST) begin
                     state       <= SHOW;
                     cnt         <= '0;
                     o_digitEnN  <= ~curOneHot;
                     o_segNibble <= curNibble;
                     o_segBlank  <= lzBlank;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               SHOW: begin
                  o_frameDone <= 1'b0;
                  if (cnt == DWELL_LAST) begin
                     state       <= GUARD;
                     cnt         <= '0;
                     idx         <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
                     o_digitEnN  <= '1;
                     o_segBlank  <= 1'b1;
                     o_segNibble <= 4'h0;
                     o_frameDone <= (idx == IDX_LAST);
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: begin
                  state <= GUARD;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, DWELL_CYCLES=4, GUARD_CYCLES=2.
// Frame vectors drive writes at chosen cycles and check every cycle of the resulting frame.
module tb_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int DWELL = 4;
   localparam int GUARD = 2;
   localparam int FRAME = ND * (DWELL + GUARD);

   logic        clk = 1'b0;
   logic        rstH;
   logic        enable;
   logic        wrEn;
   logic [15:0] wrData;
   logic [3:0]  segNibble;
   logic        segBlank;
   logic [3:0]  digitEnN;
   logic        frameDone;
   logic        pending;
   logic        dbgState;

   int nChecks = 0;
   int nPass   = 0;

   // Expected per-cycle outputs packed as {digitEnN, segBlank, segNibble, frameDone}.
   logic [9:0] exp_q[$];

   typedef struct {
      string       name;
      int          wrStepA;
      logic [15:0] dataA;
      int          wrStepB;
      logic [15:0] dataB;
      logic [15:0] expWord;
      logic        pendLast;
      logic        pendAfter;
   } frameVec_t;

   frameVec_t vecs[10];

   seg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .DWELL_CYCLES(DWELL),
      .GUARD_CYCLES(GUARD)
   ) dut (
      .i_clk      (clk),
      .i_rstH     (rstH),
      .i_enable   (enable),
      .i_wrEn     (wrEn),
      .i_wrData   (wrData),
      .o_segNibble(segNibble),
      .o_segBlank (segBlank),
      .o_digitEnN (digitEnN),
      .o_frameDone(frameDone),
      .o_pending  (pending),
      .o_dbgState (dbgState)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [9:0] expCycle(input logic [15:0] word, input int s);
      int         d;
      int         r;
      logic [3:0] en;
      logic       blank;
      logic [3:0] nib;
      logic [15:0] above;
      d = s / (DWELL + GUARD);
      r = s % (DWELL + GUARD);
      if (r >= 1 && r <= DWELL) begin
         en    = ~(4'b0001 << d);
         nib   = word[4*d +: 4];
         blank = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
         above = word >> (4*d);
         if (d > 0 && above == 16'h0) blank = 1'b1;
`else
         above = 16'h0;
`endif
         return {en, blank, nib, 1'b0};
      end
      return {4'hF, 1'b1, 4'h0, (r == DWELL + GUARD - 1) && (d == ND - 1)};
   endfunction

   task automatic runFrame(input frameVec_t v);
      logic [9:0] e;
      for (int s = 0; s < FRAME; s++) exp_q.push_back(expCycle(v.expWord, s));
      for (int s = 0; s < FRAME; s++) begin
         wrEn   = (s == v.wrStepA) || (s == v.wrStepB);
         wrData = (s == v.wrStepB) ? v.dataB : v.dataA;
         step();
         wrEn = 1'b0;
         e = exp_q.pop_front();
         check({v.name, "_digitEnN"}, 32'(digitEnN), 32'(e[9:6]));
         check({v.name, "_segBlank"}, 32'(segBlank), 32'(e[5]));
         check({v.name, "_frameDone"}, 32'(frameDone), 32'(e[0]));
         if (!e[5]) check({v.name, "_segNibble"}, 32'(segNibble), 32'(e[4:1]));
         if (s == FRAME - 2) check({v.name, "_pendLast"}, 32'(pending), 32'(v.pendLast));
         if (s == FRAME - 1) check({v.name, "_pendAfter"}, 32'(pending), 32'(v.pendAfter));
      end
   endtask

   initial begin
      vecs[0] = '{"frame_1a2f",     -1, 16'h0,    -1, 16'h0,    16'h1A2F, 1'b0, 1'b0};
      vecs[1] = '{"wr_mid_frame",    8, 16'h0003, -1, 16'h0,    16'h1A2F, 1'b1, 1'b0};
      vecs[2] = '{"shows_0003",     -1, 16'h0,    -1, 16'h0,    16'h0003, 1'b0, 1'b0};
      vecs[3] = '{"wr_at_boundary", 10, 16'h5678, 23, 16'hBEEF, 16'h0003, 1'b1, 1'b1};
      vecs[4] = '{"shows_old_5678", -1, 16'h0,    -1, 16'h0,    16'h5678, 1'b1, 1'b0};
      vecs[5] = '{"shows_beef",     -1, 16'h0,    -1, 16'h0,    16'hBEEF, 1'b0, 1'b0};
      vecs[6] = '{"last_wr_wins",    3, 16'h1111, 15, 16'h2222, 16'hBEEF, 1'b1, 1'b0};
      vecs[7] = '{"shows_2222",      5, 16'h0030, -1, 16'h0,    16'h2222, 1'b1, 1'b0};
      vecs[8] = '{"shows_0030",      5, 16'h0000, -1, 16'h0,    16'h0030, 1'b1, 1'b0};
      vecs[9] = '{"shows_0000",     -1, 16'h0,    -1, 16'h0,    16'h0000, 1'b0, 1'b0};

      rstH = 1'b1; enable = 1'b0; wrEn = 1'b0; wrData = 16'h0;
      repeat (3) step();
      check("rst_digitEnN", 32'(digitEnN), 32'hF);
      check("rst_segBlank", 32'(segBlank), 32'h1);
      check("rst_segNibble", 32'(segNibble), 32'h0);
      check("rst_frameDone", 32'(frameDone), 32'h0);
      check("rst_pending", 32'(pending), 32'h0);

      // Disabled write transfers on the following disabled cycle.
      rstH = 1'b0; wrEn = 1'b1; wrData = 16'h1A2F;
      step();
      wrEn = 1'b0;
      check("dis_wr_pending_set", 32'(pending), 32'h1);
      step();
      check("dis_wr_pending_clr", 32'(pending), 32'h0);
      check("dis_dark", 32'(digitEnN), 32'hF);

      enable = 1'b1;
      for (int i = 0; i < 10; i++) runFrame(vecs[i]);

      // Disable during SHOW of digit 2.
      repeat (14) step();
      check("pre_dis_digit2", 32'(digitEnN), 32'hB);
      enable = 1'b0;
      step();
      check("dis_digitEnN", 32'(digitEnN), 32'hF);
      check("dis_segBlank", 32'(segBlank), 32'h1);
      check("dis_frameDone", 32'(frameDone), 32'h0);
      wrEn = 1'b1; wrData = 16'h4321;
      step();
      wrEn = 1'b0;
      check("dis2_pending_set", 32'(pending), 32'h1);
      step();
      check("dis2_pending_clr", 32'(pending), 32'h0);

      // Re-enable: two guard cycles then digit 0.
      enable = 1'b1;
      step();
      check("reen_guard", 32'(digitEnN), 32'hF);
      check("reen_guard_blank", 32'(segBlank), 32'h1);
      step();
      check("reen_digit0_en", 32'(digitEnN), 32'hE);
      check("reen_digit0_nib", 32'(segNibble), 32'h1);
      check("reen_digit0_blank", 32'(segBlank), 32'h0);

      // Reset mid-scan with a pending write.
      step();
      wrEn = 1'b1; wrData = 16'h9999;
      step();
      wrEn = 1'b0;
      check("mid_pending", 32'(pending), 32'h1);
      rstH = 1'b1;
      step();
      check("midrst_digitEnN", 32'(digitEnN), 32'hF);
      check("midrst_segBlank", 32'(segBlank), 32'h1);
      check("midrst_pending", 32'(pending), 32'h0);
      rstH = 1'b0;
      repeat (2) step();
      check("post_rst_digit0_en", 32'(digitEnN), 32'hE);
      check("post_rst_digit0_nib", 32'(segNibble), 32'h0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
